reg_file_dumper: RTL and testbench

- Debug-side reader for the CPU register file.
- On a start pulse it walks registers 0..N_REGS-1 through one register-file read port.
- Each 32-bit word is split into bytes and handed to the debug UART transmitter over a valid/ready handshake.
- It sits between reg_file (second read port or debug mux) and the UART TX in the debug unit.

---
 rtl/reg_file_dumper_pkg.sv | 22 ++
 rtl/reg_file_dumper_word_serializer.sv | 54 +++++
 rtl/reg_file_dumper.sv | 88 ++++++++
 tb/tb_reg_file_dumper.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_dumper_pkg.sv
// Shared debug-unit definitions: dumper state encoding, TX byte width and word/byte sizing helpers.
package reg_file_dumper_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LOAD,
        ST_SEND,
        ST_DONE
    } state_t;

    localparam int DBG_NB_BYTE = 8;

    function automatic int bytes_per_word(input int nb_data, input int nb_byte);
        return nb_data / nb_byte;
    endfunction

    function automatic int cnt_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_file_dumper_word_serializer.sv
// Splits a loaded word into bytes, MSB first, under valid/ready; valid rises the cycle after load.
// Data and valid hold while ready is low; last_accepted strobes on the final byte's handshake.
module reg_file_dumper_word_serializer
    import reg_file_dumper_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_BYTE = DBG_NB_BYTE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [NB_DATA-1:0] word,
    output logic [NB_BYTE-1:0] tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               last_accepted
);

    localparam int BPW    = bytes_per_word(NB_DATA, NB_BYTE);
    localparam int NB_CNT = cnt_bits(BPW);
    localparam logic [NB_CNT-1:0] LAST_BYTE = NB_CNT'(BPW - 1);

    logic [NB_DATA-1:0] word_q;
    logic [NB_CNT-1:0]  cnt_q;
    logic               vld_q;
    logic               fire;

    assign fire          = vld_q & tx_ready;
    assign last_accepted = fire & (cnt_q == LAST_BYTE);
    assign tx_valid      = vld_q;
    // The word shifts left on each accepted byte, so the current byte is always the top slice.
    assign tx_data       = word_q[NB_DATA-1 -: NB_BYTE];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
            cnt_q  <= '0;
            vld_q  <= 1'b0;
        end else if (load) begin
            word_q <= word;
            cnt_q  <= '0;
            vld_q  <= 1'b1;
        end else if (fire) begin
            word_q <= word_q << NB_BYTE;
            if (cnt_q == LAST_BYTE) begin
                cnt_q <= '0;
                vld_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_file_dumper.sv
// Walks register indices 0..N_REGS-1 on start and streams each word to UART TX, MSB byte first.
// 6 cycles per register with TX always ready; a stalled TX simply holds the current byte.
module reg_file_dumper
    import reg_file_dumper_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 5,
    parameter int N_REGS  = 32,
    parameter int NB_BYTE = DBG_NB_BYTE
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [NB_DATA-1:0] i_rd_data,
    output logic [NB_ADDR-1:0] o_rd_reg,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_busy,
    output logic               o_done
);

    localparam logic [NB_ADDR-1:0] LAST_IDX = NB_ADDR'(N_REGS - 1);

    state_t             state;
    state_t             state_nxt;
    logic [NB_ADDR-1:0] idx_q;
    logic               load;
    logic               last_accepted;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        unique case (state)
            ST_IDLE: if (i_start) state_nxt = ST_ADDR;
            ST_ADDR: state_nxt = ST_LOAD;
            ST_LOAD: begin
                load      = 1'b1;
                state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (last_accepted) begin
                    state_nxt = (idx_q == LAST_IDX) ? ST_DONE : ST_ADDR;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Index is left at the last register after a dump and only cleared by the next start.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            idx_q <= '0;
        end else if (state == ST_IDLE && i_start) begin
            idx_q <= '0;
        end else if (state == ST_SEND && last_accepted && idx_q != LAST_IDX) begin
            idx_q <= idx_q + 1'b1;
        end
    end

    reg_file_dumper_word_serializer #(
        .NB_DATA (NB_DATA),
        .NB_BYTE (NB_BYTE)
    ) u_serializer (
        .clk           (i_clk),
        .rst           (i_rst),
        .load          (load),
        .word          (i_rd_data),
        .tx_data       (o_tx_data),
        .tx_valid      (o_tx_valid),
        .tx_ready      (i_tx_ready),
        .last_accepted (last_accepted)
    );

    assign o_rd_reg = idx_q;
    assign o_busy   = (state != ST_IDLE);
    assign o_done   = (state == ST_DONE);

endmodule

// File: tb/tb_reg_file_dumper.sv
// Bench for reg_file_dumper: expected bytes are queued per dump, a negedge monitor checks every handshake.
module tb_reg_file_dumper;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        ready_man;
    logic        rnd_bit;
    logic        rand_mode;
    logic        tx_ready;
    logic [31:0] rd_data;
    logic [4:0]  rd_reg;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        busy;
    logic        done;

    logic [31:0] regs [32];
    logic [7:0]  exp_q [$];

    int tests = 0;
    int fails = 0;
    int hs_count = 0;
    int done_count = 0;
    int busy_cycles = 0;
    int cyc = 0;
    int last_hs_cyc = 0;

    always #5 clk = ~clk;

    assign tx_ready = rand_mode ? rnd_bit : ready_man;
    assign rd_data  = regs[rd_reg];

    reg_file_dumper #(
        .NB_DATA (32),
        .NB_ADDR (5),
        .N_REGS  (32),
        .NB_BYTE (8)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_rd_data  (rd_data),
        .o_rd_reg   (rd_reg),
        .o_tx_data  (tx_data),
        .o_tx_valid (tx_valid),
        .i_tx_ready (tx_ready),
        .o_busy     (busy),
        .o_done     (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_dump();
        logic [31:0] w;
        for (int r = 0; r < 32; r++) begin
            w = regs[r];
            for (int k = 0; k < 4; k++) exp_q.push_back(w[31-8*k -: 8]);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_hs(input int target, input string name);
        int n;
        n = 0;
        while (hs_count < target && n < 5000) begin
            tick();
            n++;
        end
        if (hs_count < target) check(name, hs_count, target);
    endtask

    task automatic wait_done(input int base, input string name);
        int n;
        n = 0;
        while (done_count == base && n < 5000) begin
            tick();
            n++;
        end
        repeat (4) tick();
        check(name, done_count - base, 1);
        check({name, "_queue_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        rnd_bit = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rnd_bit = ($urandom_range(0, 99) < 30);
        end
    end

    initial begin : monitor
        logic       pv;
        logic       pr;
        logic [7:0] pd;
        pv = 1'b0;
        pr = 1'b0;
        pd = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                pv = 1'b0;
            end else begin
                if (pv && !pr) begin
                    check("hold_valid", tx_valid, 1);
                    check("hold_data", tx_data, pd);
                end
                if (tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_byte: got %0h, expected no byte", tx_data);
                    end else begin
                        check("tx_byte", tx_data, exp_q.pop_front());
                    end
                    hs_count++;
                    last_hs_cyc = cyc;
                end
                if (busy) busy_cycles++;
                if (done) begin
                    done_count++;
                    check("done_latency", cyc - last_hs_cyc, 1);
                    check("done_after_last_byte", exp_q.size(), 0);
                end
                pv = tx_valid;
                pr = tx_ready;
                pd = tx_data;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int dbase;
        int bbase;
        int n;

        rst       = 1'b1;
        start     = 1'b0;
        ready_man = 1'b1;
        rand_mode = 1'b0;
        for (int r = 0; r < 32; r++) regs[r] = (r == 0) ? 32'h0 : 32'(r + 64);

        tick();
        tick();
        check("reset_rd_reg", rd_reg, 0);
        check("reset_tx_data", tx_data, 0);
        check("reset_tx_valid", tx_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        rst = 1'b0;
        repeat (3) tick();

        // Full dump with TX always ready
        dbase = done_count;
        bbase = busy_cycles;
        base  = hs_count;
        push_dump();
        pulse_start();
        wait_done(dbase, "dump_fast_done");
        check("dump_fast_bytes", hs_count - base, 128);
        check("dump_fast_busy_cycles", busy_cycles - bbase, 193);
        check("idle_rd_reg_holds_last", rd_reg, 31);
        check("idle_busy_low", busy, 0);

        // Random backpressure
        rand_mode = 1'b1;
        dbase = done_count;
        base  = hs_count;
        push_dump();
        pulse_start();
        wait_done(dbase, "dump_random_done");
        check("dump_random_bytes", hs_count - base, 128);
        rand_mode = 1'b0;
        ready_man = 1'b1;

        // Stall on the second byte of register 5
        regs[5] = 32'hDEADBEEF;
        dbase = done_count;
        base  = hs_count;
        push_dump();
        pulse_start();
        wait_hs(base + 21, "stall_reach_byte");
        ready_man = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("stall_valid", tx_valid, 1);
            check("stall_data", tx_data, 32'hAD);
            tick();
        end
        check("stall_no_handshake", hs_count - base, 21);
        ready_man = 1'b1;
        wait_done(dbase, "dump_stall_done");
        regs[5] = 32'(5 + 64);

        // Start re-pulsed mid-dump at register 7
        dbase = done_count;
        base  = hs_count;
        push_dump();
        pulse_start();
        wait_hs(base + 28, "restart_reach_reg7");
        pulse_start();
        wait_done(dbase, "dump_restart_done");
        check("dump_restart_bytes", hs_count - base, 128);

        // Reset while register 12 byte 2 is on the bus
        dbase = done_count;
        base  = hs_count;
        push_dump();
        pulse_start();
        wait_hs(base + 50, "reset_reach_reg12");
        rst = 1'b1;
        #1;
        check("midreset_valid", tx_valid, 0);
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        repeat (5) tick();
        check("midreset_no_done", done_count - dbase, 0);
        base = hs_count;
        push_dump();
        pulse_start();
        wait_done(dbase, "dump_after_reset_done");
        check("dump_after_reset_bytes", hs_count - base, 128);

        // CPU writes register 3 the cycle after it was loaded
        dbase = done_count;
        push_dump();
        pulse_start();
        n = 0;
        while (!(tx_valid && rd_reg == 5'd3) && n < 1000) begin
            tick();
            n++;
        end
        check("reg3_send_seen", {31'b0, tx_valid}, 1);
        regs[3] = 32'h12345678;
        wait_done(dbase, "dump_write_done");
        regs[3] = 32'(3 + 64);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
